csa_accum_ctrl: RTL and testbench

//  Sequencer that sums a stream of DATA_SIZE-bit operands on one CSA (3:2 compressor)

---
 rtl/csa_accum_ctrl_if.sv | 22 ++
 rtl/csa_accum_ctrl.sv | 130 +++++++++++++
 tb/tb_csa_accum_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_ctrl_if.sv
// rtl/csa_accum_ctrl_if.sv - operand/result handshake bundle for csa_accum_ctrl
interface csa_accum_ctrl_if #(
  parameter int DATA_SIZE = 256
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - CSA multi-operand accumulator with chunked final carry-propagate add
// Optional operand counter output op_cnt enabled by defining CSA_ACCUM_CNT_EN.
module csa_accum_ctrl #(
  parameter int DATA_SIZE = 256,
  parameter int CPA_WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  csa_accum_ctrl_if.slave  bus,
  output logic             busy
`ifdef CSA_ACCUM_CNT_EN
  ,
  output logic [15:0]      op_cnt
`endif
);
  localparam int NCHUNK = DATA_SIZE / CPA_WIDTH;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] s_q, s_d;
  logic [DATA_SIZE-1:0] c_q, c_d;
  logic [DATA_SIZE-1:0] res_q, res_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 cy_q, cy_d;

  logic                 in_xfer;
  logic [DATA_SIZE-1:0] csa_s;
  logic [DATA_SIZE-1:0] csa_c;
  logic [CPA_WIDTH:0]   chunk_sum;
  int                   kidx;

  assign bus.in_ready  = (state_q == IDLE) | (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = res_q;
  assign busy          = (state_q != IDLE);
  assign in_xfer       = bus.in_valid & bus.in_ready;

  // Carry vector shifted left by one; the carry out of the MSB wraps away (mod 2^DATA_SIZE).
  assign csa_s = s_q ^ c_q ^ bus.in_data;
  assign csa_c = ((s_q & c_q) | (s_q & bus.in_data) | (c_q & bus.in_data)) << 1;

  assign kidx      = int'(k_q);
  assign chunk_sum = {1'b0, s_q[kidx*CPA_WIDTH +: CPA_WIDTH]}
                   + {1'b0, c_q[kidx*CPA_WIDTH +: CPA_WIDTH]}
                   + {{CPA_WIDTH{1'b0}}, cy_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    k_d     = k_q;
    cy_d    = cy_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          s_d     = bus.in_data;
          c_d     = '0;
          k_d     = '0;
          cy_d    = 1'b0;
          state_d = bus.in_last ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          s_d  = csa_s;
          c_d  = csa_c;
          k_d  = '0;
          cy_d = 1'b0;
          if (bus.in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        res_d[kidx*CPA_WIDTH +: CPA_WIDTH] = chunk_sum[CPA_WIDTH-1:0];
        cy_d = chunk_sum[CPA_WIDTH];
        if (k_q == K_LAST) state_d = DONE;
        else               k_d = k_q + KW'(1);
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
    end
  end

`ifdef CSA_ACCUM_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer) begin
      if (state_q == IDLE)          cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF)   cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign op_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - directed self-checking bench for csa_accum_ctrl
module tb_csa_accum_ctrl;
  localparam int DS = 256;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef CSA_ACCUM_CNT_EN
  logic [15:0] op_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  csa_accum_ctrl_if #(.DATA_SIZE(DS)) bus ();

  csa_accum_ctrl #(.DATA_SIZE(DS), .CPA_WIDTH(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
`ifdef CSA_ACCUM_CNT_EN
    ,
    .op_cnt (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until the accepting edge; returns #1 after that edge.
  task automatic send_op(input string tag, input logic [DS-1:0] d, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check({tag, "_accept_timeout"}, 0, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called right after the in_last accept; follows the group until it returns to IDLE.
  task automatic collect(output int lat, output int busy_n, output logic [DS-1:0] res, output logic got);
    int cyc;
    lat = -1; busy_n = 0; res = '0; got = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      if (!busy) break;
      busy_n++;
      if (bus.out_valid && !got) begin
        got = 1'b1;
        lat = cyc;
        res = bus.out_data;
      end
      tick();
    end
  endtask

  task automatic expect_group(input string tag, input logic [DS-1:0] exp);
    int lat, bn;
    logic [DS-1:0] res;
    logic got;
    collect(lat, bn, res, got);
    check({tag, "_got"}, DS'(got), DS'(1));
    check({tag, "_data"}, res, exp);
  endtask

  logic [DS-1:0] max_v, half_v, chunk0_max;
  int lat, bn;
  logic [DS-1:0] res;
  logic got;

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    max_v      = '1;
    half_v     = DS'(1) << 255;
    chunk0_max = {192'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tick(); tick();
    check("rst_out_valid", DS'(bus.out_valid), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", DS'(busy), 0);
`ifdef CSA_ACCUM_CNT_EN
    check("rst_op_cnt", DS'(op_cnt), 0);
`endif
    rst = 1'b0;
    tick();

    // 1: single operand
    send_op("t1", DS'(32'h1234), 1'b1);
    collect(lat, bn, res, got);
    check("t1_latency", DS'(lat), DS'(4));
    check("t1_data", res, DS'(32'h1234));
    check("t1_busy_cycles", DS'(bn), DS'(5));

    // 2: back-to-back 1,2,3 with in_ready checked before each accept
    bus.in_valid = 1'b1; bus.in_last = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = DS'(i);
      bus.in_last = (i == 3);
      check($sformatf("t2_ready_%0d", i), DS'(bus.in_ready), DS'(1));
      tick();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    collect(lat, bn, res, got);
    check("t2_data", res, DS'(6));
    check("t2_latency", DS'(lat), DS'(4));
`ifdef CSA_ACCUM_CNT_EN
    check("t2_op_cnt", DS'(op_cnt), DS'(3));
`endif

    // 3: carry crossing chunk 0 -> 1
    send_op("t3a", chunk0_max, 1'b0);
    send_op("t3b", DS'(1), 1'b1);
    expect_group("t3", DS'(1) << 64);

    // 4: modular wrap
    send_op("t4a", max_v, 1'b0);
    send_op("t4b", DS'(1), 1'b1);
    expect_group("t4_wrap1", '0);
    send_op("t4c", half_v, 1'b0);
    send_op("t4d", half_v, 1'b0);
    send_op("t4e", DS'(5), 1'b1);
    expect_group("t4_wrap2", DS'(5));

    // 5: backpressure in DONE with ignored in_valid pulses
    bus.out_ready = 1'b0;
    send_op("t5a", DS'(10), 1'b0);
    send_op("t5b", DS'(20), 1'b1);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = DS'(32'h99);
      bus.in_last  = 1'b1;
      check($sformatf("t5_valid_%0d", i), DS'(bus.out_valid), DS'(1));
      check($sformatf("t5_data_%0d", i), bus.out_data, DS'(30));
      check($sformatf("t5_ready_%0d", i), DS'(bus.in_ready), DS'(0));
      tick();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t5_valid_drop", DS'(bus.out_valid), DS'(0));
    send_op("t5c", DS'(1), 1'b1);
    expect_group("t5_next", DS'(1));
`ifdef CSA_ACCUM_CNT_EN
    check("t5_next_op_cnt", DS'(op_cnt), DS'(1));
`endif

    // 6: reset during RESOLVE at k=2, then a fresh group
    send_op("t6a", DS'(100), 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_rst_valid", DS'(bus.out_valid), DS'(0));
    check("t6_rst_data", bus.out_data, DS'(0));
    check("t6_rst_busy", DS'(busy), DS'(0));
    rst = 1'b0;
    send_op("t6b", DS'(5), 1'b0);
    send_op("t6c", DS'(7), 1'b1);
    expect_group("t6", DS'(12));
`ifdef CSA_ACCUM_CNT_EN
    check("t6_op_cnt", DS'(op_cnt), DS'(2));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
